// File: rtl/cpu_button_driver_if.sv
// Bundle of the opponent's control inputs and emulated-key outputs.
// The game-side controller uses master; the button driver uses slave.
interface cpu_button_driver_if #(
  parameter int DIFF_W = 9,
  parameter int CNT_W  = 8
);
  logic              enable;
  logic [DIFF_W-1:0] difficulty;
  logic              button_out;
  logic              busy;
  logic [CNT_W-1:0]  press_count;

  modport master (
    output enable,
    output difficulty,
    input  button_out,
    input  busy,
    input  press_count
  );

  modport slave (
    input  enable,
    input  difficulty,
    output button_out,
    output busy,
    output press_count
  );
endinterface

// File: rtl/cpu_button_driver.sv
// Computer opponent: emits fixed-length button presses whenever a free-running
// LFSR sample falls below the difficulty threshold, with a forced release gap.
module cpu_button_driver #(
  parameter int LFSR_W      = 10,
  parameter int DIFF_W      = 9,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  cpu_button_driver_if.slave  bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [LFSR_W-1:0]   lfsr;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [GAP_W-1:0]    gap_cnt, gap_d;
  logic [CNT_W-1:0]    press_count;
  logic                button_q;
  logic                busy_q;
  logic                trigger;
  logic                count_inc;

  // XNOR feedback makes all-zero a legal seed; all-ones is the lockup value.
  assign trigger = bus.enable && (lfsr[DIFF_W-1:0] < bus.difficulty);

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    gap_d     = gap_cnt;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_d = PRESS;
          hold_d  = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      PRESS: begin
        if (hold_cnt == '0) begin
          state_d   = GAP;
          gap_d     = GAP_W'(GAP_CYCLES - 1);
          count_inc = 1'b1;
        end else begin
          hold_d = hold_cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_d   = gap_cnt - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      press_count <= '0;
      button_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state    <= state_d;
      lfsr     <= {lfsr[LFSR_W-2:0], ~(lfsr[9] ^ lfsr[6])};
      hold_cnt <= hold_d;
      gap_cnt  <= gap_d;
      // Outputs are decoded from the next state so they line up with the state flop.
      button_q <= (state_d == PRESS);
      busy_q   <= (state_d != IDLE);
      if (count_inc) press_count <= press_count + CNT_W'(1);
    end
  end

  assign bus.button_out  = button_q;
  assign bus.busy        = busy_q;
  assign bus.press_count = press_count;

endmodule

// File: tb/tb_cpu_button_driver.sv
// Directed bench for cpu_button_driver: per-cycle vector table plus long-run
// LFSR statistics and a narrow-counter wrap sequence on a second instance.
module tb_cpu_button_driver;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_button_driver_if #(.DIFF_W(9), .CNT_W(8)) bus ();
  cpu_button_driver_if #(.DIFF_W(9), .CNT_W(3)) bus3 ();

  cpu_button_driver #(
    .LFSR_W(10), .DIFF_W(9), .HOLD_CYCLES(2), .GAP_CYCLES(2), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  cpu_button_driver #(
    .LFSR_W(10), .DIFF_W(9), .HOLD_CYCLES(2), .GAP_CYCLES(2), .CNT_W(3)
  ) dut_w3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [8:0] diff;
    logic       exp_b;
    logic       exp_busy;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic [8:0] d,
                              input logic b, input logic bs, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.diff = d; v.exp_b = b; v.exp_busy = bs; v.exp_cnt = c;
    tbl.push_back(v);
  endfunction

  function automatic logic [9:0] lfsr_next(input logic [9:0] m);
    return {m[8:0], ~(m[9] ^ m[6])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_high;
    logic [9:0] m;
    int t, model_starts, dut_falls, lfsr_bad, allones;
    logic prev_b;
    logic [2:0] prev3;
    int waited;

    reset = 1'b1;
    bus.enable = 1'b1;
    bus.difficulty = 9'd0;
    bus3.enable = 1'b1;
    bus3.difficulty = 9'd511;

    // Test 1: difficulty 0 never presses.
    repeat (3) step();
    check("reset button", bus.button_out, 0);
    check("reset busy", bus.busy, 0);
    check("reset count", bus.press_count, 0);
    reset = 1'b0;
    seen_high = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.button_out) seen_high++;
    end
    check("diff0 button high cycles", seen_high, 0);
    check("diff0 count", bus.press_count, 0);

    // Max difficulty from reset: 1,1,0,0,0 with period 5.
    add(1, 1, 511, 0, 0, 0);
    for (int p = 0; p < 4; p++) begin
      add(0, 1, 511, 1, 1, 8'(p));
      add(0, 1, 511, 1, 1, 8'(p));
      add(0, 1, 511, 0, 1, 8'(p + 1));
      add(0, 1, 511, 0, 1, 8'(p + 1));
      add(0, 1, 511, 0, 0, 8'(p + 1));
    end
    // Enable dropped on the second PRESS cycle: press completes, no more follow.
    add(1, 1, 511, 0, 0, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 0, 511, 1, 1, 0);
    add(0, 0, 511, 0, 1, 1);
    add(0, 0, 511, 0, 1, 1);
    add(0, 0, 511, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 511, 0, 0, 1);
    // Reset during the second press, then the max-difficulty pattern again.
    add(1, 1, 511, 0, 0, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 0, 1);
    add(0, 1, 511, 1, 1, 1);
    add(1, 1, 511, 0, 0, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 0, 1);
    // Difficulty raised while idle takes effect at the next evaluation (lfsr=003).
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 1, 1, 0);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 1, 1);
    add(0, 1, 511, 0, 0, 1);
    // Difficulty 1: strict compare fires only on lfsr=0, not on 01F/03F.
    add(1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 1, 0);
    add(0, 1, 1, 0, 1, 1);
    add(0, 1, 1, 0, 1, 1);
    add(0, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      bus.enable = tbl[i].en;
      bus.difficulty = tbl[i].diff;
      step();
      check($sformatf("vec%0d button", i), bus.button_out, tbl[i].exp_b);
      check($sformatf("vec%0d busy", i), bus.busy, tbl[i].exp_busy);
      check($sformatf("vec%0d count", i), bus.press_count, tbl[i].exp_cnt);
    end

    // Test 5: difficulty 256 over ten LFSR periods against a golden model.
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.difficulty = 9'd256;
    step();
    reset = 1'b0;
    m = '0; t = 0; model_starts = 0; dut_falls = 0; lfsr_bad = 0; allones = 0;
    prev_b = 1'b0;
    for (int i = 0; i < 10230; i++) begin
      if (t == 0) begin
        if (m[8:0] < 9'd256) begin
          t = 4;
          model_starts++;
        end
      end else begin
        t--;
      end
      m = lfsr_next(m);
      step();
      if (dut.lfsr !== m) lfsr_bad++;
      if (dut.lfsr === 10'h3FF) allones++;
      if (prev_b && !bus.button_out) dut_falls++;
      prev_b = bus.button_out;
    end
    check($sformatf("diff256 presses %0d vs model %0d within 10pct", dut_falls, model_starts),
          ((dut_falls - model_starts) * 10 <= model_starts) &&
          ((model_starts - dut_falls) * 10 <= model_starts) && (model_starts > 0), 1);
    check("diff256 lfsr vs model cycles off", lfsr_bad, 0);
    check("diff256 lfsr all-ones cycles", allones, 0);
    check("diff256 press_count low bits", bus.press_count, dut_falls % 256);

    // Test 6: 3-bit counter wraps 1..7,0,1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("w3 count after reset", bus3.press_count, 0);
    prev3 = bus3.press_count;
    for (int k = 1; k <= 9; k++) begin
      waited = 0;
      while (bus3.press_count === prev3 && waited < 20) begin
        step();
        waited++;
      end
      if (waited >= 20) begin
        check($sformatf("w3 press %0d timeout", k), 1, 0);
      end else begin
        check($sformatf("w3 press %0d count", k), bus3.press_count, k % 8);
      end
      prev3 = bus3.press_count;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
